cursor_select_ctrl: RTL and testbench

CURSOR_SELECT_CTRL -- requirements
Module: cursor_select_ctrl

---
 rtl/cursor_select_ctrl.sv | 150 +++++++++++++++
 tb/tb_cursor_select_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_select_ctrl.sv
// Cursor navigation and two-card select/compare controller for a 6x6 memory board.
// Fetches both card types through a shared combinational lookup port, one per cycle.
module cursor_select_ctrl (
    input  logic        clk100_in,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sel,
    output logic [5:0]  type_addr,
    input  logic [3:0]  type_data,
    output logic [35:0] hidden_bus,
    output logic [35:0] blink_bus,
    output logic [35:0] sel_bus,
    output logic [4:0]  pair_count,
    output logic        cleared
);

    typedef enum logic [1:0] {IDLE, ONE, FETCH_A, FETCH_B} state_t;

    state_t      state, state_nxt;
    logic [2:0]  row, col, row_nxt, col_nxt;
    logic [4:0]  btn_now, btn_prev, btn_prev_nxt, btn_edge;
    logic [5:0]  cur_idx, a_idx, b_idx, a_nxt, b_nxt;
    logic [3:0]  ta, ta_nxt;
    logic [35:0] hidden_nxt, sel_nxt, blink_nxt;
    logic [4:0]  pc_nxt;
    logic        cleared_nxt;

    function automatic logic [5:0] card_idx(input logic [2:0] r, input logic [2:0] c);
        return 6'(c) + 6'(r) * 6'd6;
    endfunction

    assign btn_now  = {btn_sel, btn_right, btn_left, btn_down, btn_up};
    assign btn_edge = btn_now & ~btn_prev;
    assign cur_idx  = card_idx(row, col);

    always_comb begin
        case (state)
            FETCH_A: type_addr = a_idx;
            FETCH_B: type_addr = b_idx;
            default: type_addr = cur_idx;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        row_nxt      = row;
        col_nxt      = col;
        btn_prev_nxt = btn_prev;
        a_nxt        = a_idx;
        b_nxt        = b_idx;
        ta_nxt       = ta;
        hidden_nxt   = hidden_bus;
        sel_nxt      = sel_bus;
        blink_nxt    = blink_bus;
        pc_nxt       = pair_count;
        cleared_nxt  = cleared;

        // Once cleared, everything (including edge history) freezes until reset.
        if (!cleared) begin
            btn_prev_nxt = btn_now;

            if (btn_edge[0])
                row_nxt = (row == 3'd0) ? 3'd5 : row - 3'd1;
            else if (btn_edge[1])
                row_nxt = (row == 3'd5) ? 3'd0 : row + 3'd1;
            else if (btn_edge[2])
                col_nxt = (col == 3'd0) ? 3'd5 : col - 3'd1;
            else if (btn_edge[3])
                col_nxt = (col == 3'd5) ? 3'd0 : col + 3'd1;

            // Selection acts on cur_idx, i.e. the cursor before any same-cycle move.
            case (state)
                IDLE: begin
                    if (btn_edge[4] && !hidden_bus[cur_idx]) begin
                        sel_nxt[cur_idx] = 1'b1;
                        a_nxt            = cur_idx;
                        state_nxt        = ONE;
                    end
                end
                ONE: begin
                    if (btn_edge[4] && !hidden_bus[cur_idx]) begin
                        if (cur_idx == a_idx) begin
                            sel_nxt[a_idx] = 1'b0;
                            state_nxt      = IDLE;
                        end else begin
                            sel_nxt[cur_idx] = 1'b1;
                            b_nxt            = cur_idx;
                            state_nxt        = FETCH_A;
                        end
                    end
                end
                FETCH_A: begin
                    ta_nxt    = type_data;
                    state_nxt = FETCH_B;
                end
                FETCH_B: begin
                    sel_nxt = '0;
                    if (type_data == ta) begin
                        hidden_nxt[a_idx] = 1'b1;
                        hidden_nxt[b_idx] = 1'b1;
                        if (pair_count < 5'd18)
                            pc_nxt = pair_count + 5'd1;
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase

            blink_nxt = 36'd1 << card_idx(row_nxt, col_nxt);
            if (&hidden_bus) begin
                cleared_nxt = 1'b1;
                blink_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk100_in or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            btn_prev   <= '1;
            a_idx      <= '0;
            b_idx      <= '0;
            ta         <= '0;
            hidden_bus <= '0;
            sel_bus    <= '0;
            blink_bus  <= 36'h1;
            pair_count <= '0;
            cleared    <= 1'b0;
        end else begin
            state      <= state_nxt;
            row        <= row_nxt;
            col        <= col_nxt;
            btn_prev   <= btn_prev_nxt;
            a_idx      <= a_nxt;
            b_idx      <= b_nxt;
            ta         <= ta_nxt;
            hidden_bus <= hidden_nxt;
            sel_bus    <= sel_nxt;
            blink_bus  <= blink_nxt;
            pair_count <= pc_nxt;
            cleared    <= cleared_nxt;
        end
    end

endmodule

// File: tb/tb_cursor_select_ctrl.sv
// Directed bench for cursor_select_ctrl: navigation, select/compare, clearing and reset abort.
// Card types come from a fixed table where cards 0/7 match and 0/1 differ.
module tb_cursor_select_ctrl;

    logic        clk100_in = 1'b0;
    logic        rst;
    logic [4:0]  btns;
    logic [5:0]  type_addr;
    logic [3:0]  type_data;
    logic [35:0] hidden_bus, blink_bus, sel_bus;
    logic [4:0]  pair_count;
    logic        cleared;

    int n_checks = 0;
    int n_errors = 0;
    int tb_r = 0;
    int tb_c = 0;

    cursor_select_ctrl dut (
        .clk100_in (clk100_in),
        .rst       (rst),
        .btn_up    (btns[0]),
        .btn_down  (btns[1]),
        .btn_left  (btns[2]),
        .btn_right (btns[3]),
        .btn_sel   (btns[4]),
        .type_addr (type_addr),
        .type_data (type_data),
        .hidden_bus(hidden_bus),
        .blink_bus (blink_bus),
        .sel_bus   (sel_bus),
        .pair_count(pair_count),
        .cleared   (cleared)
    );

    always #5 clk100_in = ~clk100_in;

    // Types pair up as (2k,2k+1), except cards 1 and 7 swap partners.
    function automatic logic [3:0] card_type(input logic [5:0] i);
        logic [5:0] j;
        j = i;
        if (i == 6'd1) j = 6'd7;
        else if (i == 6'd7) j = 6'd1;
        return 4'(j / 6'd2);
    endfunction

    assign type_data = card_type(type_addr);

    function automatic logic [35:0] bit_at(input int i);
        return 36'd1 << i;
    endfunction

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic press(input int b);
        btns[b] = 1'b1;
        @(negedge clk100_in);
        btns[b] = 1'b0;
        @(negedge clk100_in);
        case (b)
            0: tb_r = (tb_r + 5) % 6;
            1: tb_r = (tb_r + 1) % 6;
            2: tb_c = (tb_c + 5) % 6;
            3: tb_c = (tb_c + 1) % 6;
            default: ;
        endcase
    endtask

    task automatic goto(input int r, input int c);
        while (tb_r != r) press(1);
        while (tb_c != c) press(3);
    endtask

    task automatic pick(input int idx);
        goto(idx / 6, idx % 6);
        press(4);
    endtask

    task automatic clear_pair(input int x, input int y);
        pick(x);
        pick(y);
        @(negedge clk100_in);
    endtask

    initial begin
        btns = '0;
        rst  = 1'b1;
        #2;
        check("rst_blink",   blink_bus, 36'h1);
        check("rst_hidden",  hidden_bus, '0);
        check("rst_sel",     sel_bus, '0);
        check("rst_pc",      36'(pair_count), '0);
        check("rst_cleared", 36'(cleared), '0);
        check("rst_taddr",   36'(type_addr), '0);
        @(negedge clk100_in);
        @(negedge clk100_in);
        rst = 1'b0;
        @(negedge clk100_in);

        // Navigation with wrap-around
        repeat (7) press(3);
        check("right7", blink_bus, 36'h2);
        press(2);
        press(0);
        check("up_wrap", blink_bus, bit_at(30));
        press(1);
        check("down_back", blink_bus, 36'h1);

        // Mismatching pair 0/1
        press(4);
        check("mis_sel0", sel_bus, 36'h1);
        press(3);
        press(4);
        check("mis_taddr_b", 36'(type_addr), 36'd1);
        @(negedge clk100_in);
        check("mis_sel", sel_bus, '0);
        check("mis_hidden", hidden_bus, '0);
        check("mis_pc", 36'(pair_count), '0);
        press(2);

        // Select and deselect the same card
        press(4);
        check("tog_on", sel_bus, 36'h1);
        press(4);
        check("tog_off", sel_bus, '0);

        // Matching pair 0/7 with cycle-accurate latency
        press(4);
        goto(1, 1);
        btns[4] = 1'b1;
        @(negedge clk100_in);
        btns[4] = 1'b0;
        check("m_sel_both", sel_bus, 36'h81);
        check("m_taddr_a", 36'(type_addr), 36'd0);
        check("m_hid_n1", hidden_bus, '0);
        @(negedge clk100_in);
        check("m_taddr_b", 36'(type_addr), 36'd7);
        check("m_hid_n2", hidden_bus, '0);
        @(negedge clk100_in);
        check("m_hid_n3", hidden_bus, 36'h81);
        check("m_sel_n3", sel_bus, '0);
        check("m_pc", 36'(pair_count), 36'd1);

        // Up + left + select together at card 8: select uses pre-move index, only up moves
        press(3);
        btns = 5'b10101;
        @(negedge clk100_in);
        btns = '0;
        @(negedge clk100_in);
        tb_r = 0;
        check("multi_sel", sel_bus, bit_at(8));
        check("multi_blink", blink_bus, bit_at(2));
        press(1);
        press(4);
        check("multi_desel", sel_bus, '0);

        // Selects on hidden cards are ignored in IDLE and ONE
        press(2);
        press(4);
        check("hid_idle", sel_bus, '0);
        press(3);
        press(4);
        press(2);
        press(4);
        check("hid_one", sel_bus, bit_at(8));

        // Pair 8/9 with a select edge landing while the compare is in flight
        press(3);
        press(3);
        btns[4] = 1'b1;
        @(negedge clk100_in);
        btns[4] = 1'b0;
        check("fa_sel", sel_bus, bit_at(8) | bit_at(9));
        @(negedge clk100_in);
        btns[4] = 1'b1;
        check("fb_sel", sel_bus, bit_at(8) | bit_at(9));
        @(negedge clk100_in);
        btns[4] = 1'b0;
        check("fb_hidden", hidden_bus, 36'h381);
        check("fb_selclr", sel_bus, '0);
        check("fb_pc", 36'(pair_count), 36'd2);
        @(negedge clk100_in);
        check("fb_sel_after", sel_bus, '0);

        // Clear the remaining 16 pairs
        clear_pair(1, 6);
        clear_pair(2, 3);
        clear_pair(4, 5);
        for (int p = 5; p < 18; p++) clear_pair(2 * p, 2 * p + 1);
        check("clr_hidden", hidden_bus, '1);
        check("clr_pc", 36'(pair_count), 36'd18);
        check("clr_not_yet", 36'(cleared), '0);
        @(negedge clk100_in);
        check("clr_flag", 36'(cleared), 36'd1);
        check("clr_blink", blink_bus, '0);
        press(3);
        press(0);
        press(4);
        check("frz_blink", blink_bus, '0);
        check("frz_sel", sel_bus, '0);
        check("frz_hidden", hidden_bus, '1);
        check("frz_pc", 36'(pair_count), 36'd18);
        check("frz_cleared", 36'(cleared), 36'd1);

        // Asynchronous reset from the cleared board
        rst = 1'b1;
        #1;
        check("ar_blink", blink_bus, 36'h1);
        check("ar_hidden", hidden_bus, '0);
        check("ar_cleared", 36'(cleared), '0);
        @(negedge clk100_in);
        rst  = 1'b0;
        tb_r = 0;
        tb_c = 0;
        @(negedge clk100_in);

        // Reset during FETCH_B aborts the compare of 0/7
        press(4);
        goto(1, 1);
        btns[4] = 1'b1;
        @(negedge clk100_in);
        btns[4] = 1'b0;
        @(negedge clk100_in);
        #2;
        rst = 1'b1;
        #1;
        check("abort_hidden", hidden_bus, '0);
        check("abort_sel", sel_bus, '0);
        check("abort_pc", 36'(pair_count), '0);
        check("abort_blink", blink_bus, 36'h1);
        check("abort_taddr", 36'(type_addr), '0);
        @(negedge clk100_in);
        @(negedge clk100_in);
        rst = 1'b0;
        repeat (3) @(negedge clk100_in);
        check("post_hidden", hidden_bus, '0);
        check("post_sel", sel_bus, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
